// File: rtl/riscv_exec_pkg.sv
// Shared constants for the RV32I execute slice: data width and ALU operation codes.
package riscv_exec_pkg;

  localparam int XLEN      = 32;
  localparam int ALU_CTL_W = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL  = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD2 = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL  = 4'd5;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_AND  = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT  = 4'd9;
  localparam logic [ALU_CTL_W-1:0] ALU_SRA  = 4'd10;

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit integer ALU; unassigned op codes yield zero.
module exec_alu
  import riscv_exec_pkg::*;
(
  input  logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  output logic [XLEN-1:0]      result,
  output logic                 zero
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_ADD, ALU_ADD2: result = a + b;
      ALU_SLL:           result = a << shamt;
      ALU_SLTU:          result = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:           result = a ^ b;
      ALU_SRL:           result = a >> shamt;
      ALU_SUB:           result = a - b;
      ALU_AND:           result = a & b;
      ALU_OR:            result = a | b;
      ALU_SLT:           result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SRA:           result = $unsigned($signed(a) >>> shamt);
      default:           result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/riscv_exec_unit.sv
// PC register, ALU and word-addressed data memory for the single-cycle RV32I core.
// Define DMEM_CLEAR_EN to make reset clear every data-memory word.
module riscv_exec_unit
  import riscv_exec_pkg::*;
#(
  parameter int              DMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcnext,
  input  logic [XLEN-1:0]      pc_target,
  output logic [XLEN-1:0]      pc_reg,
  input  logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic [XLEN-1:0]      alu_a,
  input  logic [XLEN-1:0]      alu_b,
  output logic [XLEN-1:0]      alu_out,
  output logic                 zero,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [XLEN-1:0]      write_data,
  output logic [XLEN-1:0]      read_data,
  output logic [XLEN-1:0]      wb_data
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] mem_q [DMEM_DEPTH];
  logic [AW-1:0]   mem_idx;
  logic            unused_pc_target_bits;

  // Targets are forced word-aligned, so the low bits never reach the PC.
  assign unused_pc_target_bits = ^pc_target[1:0];

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (pcnext) begin
      pc_d = {pc_target[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_reg = pc_q;

  exec_alu u_alu (
    .alu_ctl (alu_ctl),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_out),
    .zero    (zero)
  );

  // Byte address -> word index; upper bits drop out so addresses wrap.
  assign mem_idx = alu_out[AW+1:2];

`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write) begin
      mem_q[mem_idx] <= write_data;
    end
  end
`else
  // Reset only gates the write; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && mem_write) begin
      mem_q[mem_idx] <= write_data;
    end
  end
`endif

  assign read_data = mem_read ? mem_q[mem_idx] : '0;
  assign wb_data   = mem_read ? read_data : alu_out;

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Directed self-checking bench for riscv_exec_unit: PC sequencing, ALU codes, memory access.
module tb_riscv_exec_unit;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        pcnext;
  logic [31:0] pc_target;
  logic [31:0] pc_reg;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        zero;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  riscv_exec_unit #(
    .DMEM_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pcnext     (pcnext),
    .pc_target  (pc_target),
    .pc_reg     (pc_reg),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .zero       (zero),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_data (write_data),
    .read_data  (read_data),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    alu_ctl = ctl;
    alu_a   = a;
    alu_b   = b;
    #1;
    check(tag, alu_out, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    pcnext     = 1'b0;
    pc_target  = '0;
    alu_ctl    = 4'd0;
    alu_a      = '0;
    alu_b      = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = '0;

    // PC reset and sequential advance
    #2;
    check("pc_in_reset", pc_reg, 32'h0);
    tick();
    reset = 1'b0;
    check("pc_after_reset", pc_reg, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("pc_seq%0d", i), pc_reg, 32'(i * 4));
    end
    #2;
    reset = 1'b1;
    #1;
    check("pc_midcycle_reset", pc_reg, 32'h0);
    tick();
    reset = 1'b0;

    // Jumps, target alignment, wrap
    pcnext = 1'b1;
    pc_target = 32'h40;
    tick();
    check("pc_jump", pc_reg, 32'h40);
    pc_target = 32'h0000_0107;
    tick();
    check("pc_jump_align", pc_reg, 32'h0000_0104);
    pc_target = 32'hFFFF_FFFC;
    tick();
    check("pc_force_top", pc_reg, 32'hFFFF_FFFC);
    pcnext = 1'b0;
    tick();
    check("pc_wrap", pc_reg, 32'h0);

    // ALU vectors
    alu_vec("sub_7_5",   4'd6,  32'd7,          32'd5,          32'd2);
    alu_vec("sub_5_5",   4'd6,  32'd5,          32'd5,          32'd0);
    alu_vec("slt_m1_1",  4'd9,  32'hFFFF_FFFF,  32'd1,          32'd1);
    alu_vec("sltu_m1_1", 4'd3,  32'hFFFF_FFFF,  32'd1,          32'd0);
    alu_vec("sra",       4'd10, 32'h8000_0000,  32'd4,          32'hF800_0000);
    alu_vec("srl",       4'd5,  32'h8000_0000,  32'd4,          32'h0800_0000);
    alu_vec("sll_b5",    4'd1,  32'h0000_0003,  32'h0000_0024,  32'h0000_0030);
    alu_vec("add0",      4'd0,  32'hFFFF_FFFF,  32'd2,          32'd1);
    alu_vec("add2",      4'd2,  32'h1000_0000,  32'h0000_0234,  32'h1000_0234);
    alu_vec("xor",       4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0);
    alu_vec("and",       4'd7,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000);
    alu_vec("or",        4'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0);
    alu_vec("slt_1_m1",  4'd9,  32'd1,          32'hFFFF_FFFF,  32'd0);
    alu_vec("sltu_1_m1", 4'd3,  32'd1,          32'hFFFF_FFFF,  32'd1);
    for (int c = 11; c <= 15; c++) begin
      alu_vec($sformatf("undef%0d", c), 4'(c), 32'h1234_5678, 32'h0000_0001, 32'd0);
    end

    // Store then load
    alu_ctl = 4'd0;
    alu_a = 32'h10;
    alu_b = 32'h4;
    write_data = 32'hDEAD_BEEF;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    mem_read = 1'b1;
    #1;
    check("load_rd", read_data, 32'hDEAD_BEEF);
    check("load_wb", wb_data, 32'hDEAD_BEEF);
    mem_read = 1'b0;
    #1;
    check("noread_rd", read_data, 32'h0);
    check("noread_wb", wb_data, 32'h14);

    // Simultaneous read and write: old word until the edge
    mem_read = 1'b1;
    mem_write = 1'b1;
    write_data = 32'hCAFE_F00D;
    #1;
    check("rw_before_edge", read_data, 32'hDEAD_BEEF);
    tick();
    mem_write = 1'b0;
    check("rw_after_edge", read_data, 32'hCAFE_F00D);
    mem_read = 1'b0;

    // Address wrap and ignored byte offset
    alu_a = 32'(DEPTH * 4 + 8);
    alu_b = 32'h0;
    write_data = 32'h1234;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    mem_read = 1'b1;
    alu_a = 32'h8;
    #1;
    check("wrap_load8", read_data, 32'h1234);
    alu_a = 32'h9;
    #1;
    check("wrap_load9", read_data, 32'h1234);
    check("wrap_load9_wb", wb_data, 32'h1234);
    mem_read = 1'b0;

    // Write attempted while reset held must be dropped
    reset = 1'b1;
    alu_a = 32'h8;
    write_data = 32'h0000_0BAD;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    reset = 1'b0;
    mem_read = 1'b1;
    #1;
`ifdef DMEM_CLEAR_EN
    check("reset_mem_cleared", read_data, 32'h0);
`else
    check("reset_mem_kept", read_data, 32'h1234);
`endif
    alu_a = 32'h14;
    #1;
`ifdef DMEM_CLEAR_EN
    check("reset_mem_cleared_14", read_data, 32'h0);
`else
    check("reset_mem_kept_14", read_data, 32'hCAFE_F00D);
`endif
    mem_read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_exec_unit.md
# riscv_exec_unit

Combined program-counter, integer ALU and word-addressed data memory for the single-cycle RV32I core. Holds the PC and advances it every clock. Evaluates one ALU operation combinationally, with the result doubling as the load/store address. Performs one memory access per cycle and provides the write-back mux the register file consumes (memory data on loads, ALU result otherwise).

## Interface
Parameters:
- DMEM_DEPTH, 256: number of 32-bit data-memory words (power of two, ≥4).
- RESET_PC, 32'h0000_0000: PC value while and after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pcnext  input  1  1 = load pc_target on next edge; 0 = PC+4.
- pc_target  input  32  branch/jump target.
- pc_reg  output  32  current PC.
- alu_ctl  input  4  ALU operation code.
- alu_a  input  32  ALU operand A.
- alu_b  input  32  ALU operand B (register or sign-extended immediate, selected upstream).
- alu_out  output  32  ALU result; also the data-memory byte address.
- zero  output  1  1 when alu_out == 0.
- mem_read  input  1  load enable.
- mem_write  input  1  store enable.
- write_data  input  32  store data.
- read_data  output  32  memory word at alu_out; 0 when mem_read = 0.
- wb_data  output  32  mem_read ? read_data : alu_out.

## Operation
- ALU, combinational, 32-bit, wrap-around, no overflow flag. Codes:
  - 0 ADD, 1 SLL (b[4:0]), 2 ADD, 3 SLTU, 4 XOR, 5 SRL (b[4:0]), 6 SUB, 7 AND, 8 OR, 9 SLT (signed), 10 SRA (b[4:0]).
  - 11–15 produce 0.
  - SLT/SLTU return 32'd1 or 32'd0.
- Code 0 must be ADD; loads, stores and ADDI issue 0. Code 2 is R-type ADD; code 6 is R-type SUB.
- Memory word index = alu_out[log2(DMEM_DEPTH)+1:2]. Bits [1:0] and the upper bits are ignored, so addresses wrap modulo DMEM_DEPTH*4.
- Read is combinational and gated by mem_read.
- Write is synchronous and full-word.
- mem_read and mem_write both high: the write occurs at the edge, and read_data shows the pre-edge word until then.

## Timing
- Reset asserted: pc_reg = RESET_PC immediately. alu_out, zero, read_data and wb_data remain combinational functions of their inputs.
- Each rising edge with reset low:
  - pc_reg <= pcnext ? {pc_target[31:2],2'b00} : pc_reg + 4.
  - PC+4 wraps: 32'hFFFF_FFFC -> 0.
- Store: mem[idx] <= write_data at the rising edge when mem_write = 1 and reset = 0. Writes are suppressed while reset is high, including when reset asserts mid-cycle.
- Read/ALU/zero/wb_data latency: 0 cycles (combinational from inputs and memory contents).
- Memory contents are undefined at power-up unless DMEM_CLEAR_EN is defined.

## Configuration
- DMEM_CLEAR_EN defined: asynchronous reset clears every data-memory word to 0 (loop in the reset branch).
- DMEM_CLEAR_EN not defined: reset leaves memory contents untouched; only the PC resets.

## Structure
- Package riscv_exec_pkg holds:
  - ALU op-code localparams (ALU_ADD=0, ALU_SLL=1, ALU_ADD2=2, ALU_SLTU=3, ALU_XOR=4, ALU_SRL=5, ALU_SUB=6, ALU_AND=7, ALU_OR=8, ALU_SLT=9, ALU_SRA=10).
  - XLEN=32.
- One sub-module, exec_alu (alu_ctl, a, b -> result, zero), instantiated once.
- PC register, memory array and write-back mux stay in the top.

## Test plan
- Reset, then 3 edges with pcnext=0 -> pc_reg 0, 4, 8, 12. Assert reset mid-cycle -> pc_reg = 0 immediately.
- pcnext=1, pc_target=32'h40 -> pc_reg 32'h40 after one edge. Separately, force PC 32'hFFFF_FFFC, pcnext=0 -> 0.
- ALU vectors:
  - a=7, b=5, ctl=6 -> 2, zero=0.
  - a=5, b=5, ctl=6 -> 0, zero=1.
  - a=32'hFFFF_FFFF, b=1, ctl=9 -> 1; ctl=3 -> 0.
  - a=32'h8000_0000, b=4, ctl=10 -> 32'hF800_0000.
  - ctl=13 -> 0.
- Store then load:
  - a=32'h10, b=4, ctl=0, mem_write=1, write_data=32'hDEAD_BEEF, one edge.
  - Then mem_read=1 with same address -> read_data = wb_data = 32'hDEAD_BEEF.
  - mem_read=0 -> read_data=0, wb_data=32'h14.
- Address wrap: store 32'h1234 at address DMEM_DEPTH*4+8, load at 8 -> 32'h1234. Load at address 9 returns the same word.
- With DMEM_CLEAR_EN defined, the store from the previous scenario followed by a reset pulse -> load returns 0. Without the macro -> 32'h1234 is retained.
